// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage registers: bubble and reset
// constants, the Tnew decrement helper and the default-width stage field bundle.
package pipe_pkg;

    localparam int          PAYLOAD_W_DEF = 96;
    localparam int          RA_W_DEF      = 5;
    localparam int          TNEW_W_DEF    = 4;
    localparam int          TNEW_MAX_W    = 32;
    localparam logic [31:0] PC_RESET_DEF  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

    // One stage entry at the default widths (pc, instr, payload, rd, regwrite, tnew).
    typedef struct packed {
        logic [31:0]              pc;
        logic [31:0]              instr;
        logic [PAYLOAD_W_DEF-1:0] payload;
        logic [RA_W_DEF-1:0]      rd;
        logic                     regwrite;
        logic [TNEW_W_DEF-1:0]    tnew;
    } stage_fields_t;

    // Saturating decrement: an entry moving one stage forward is one cycle closer
    // to producing its result, but never goes below "ready now".
    function automatic logic [TNEW_MAX_W-1:0] tnew_dec(input logic [TNEW_MAX_W-1:0] t);
        return (t == '0) ? '0 : t - TNEW_MAX_W'(1);
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One register slot of a pipeline stage: holds a valid flag plus the stage fields.
// Priority: reset > clear-to-bubble > load > hold. Clearing keeps the PC so the
// hazard unit and debug views still see the last address that passed through.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int          PAYLOAD_W = PAYLOAD_W_DEF,
    parameter int          RA_W      = RA_W_DEF,
    parameter int          TNEW_W    = TNEW_W_DEF,
    parameter logic [31:0] PC_RESET  = PC_RESET_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_load,
    input  logic                 i_clear,
    input  logic [31:0]          i_pc,
    input  logic [31:0]          i_instr,
    input  logic [PAYLOAD_W-1:0] i_payload,
    input  logic [RA_W-1:0]      i_rd,
    input  logic                 i_regwrite,
    input  logic [TNEW_W-1:0]    i_tnew,
    output logic                 o_valid,
    output logic [31:0]          o_pc,
    output logic [31:0]          o_instr,
    output logic [PAYLOAD_W-1:0] o_payload,
    output logic [RA_W-1:0]      o_rd,
    output logic                 o_regwrite,
    output logic [TNEW_W-1:0]    o_tnew
);

    logic                 r_valid;
    logic [31:0]          r_pc;
    logic [31:0]          r_instr;
    logic [PAYLOAD_W-1:0] r_payload;
    logic [RA_W-1:0]      r_rd;
    logic                 r_regwrite;
    logic [TNEW_W-1:0]    r_tnew;

    // Slot state: reset values, bubble on clear, capture on load, otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_pc       <= PC_RESET;
            r_instr    <= NOP_INSTR;
            r_payload  <= '0;
            r_rd       <= '0;
            r_regwrite <= 1'b0;
            r_tnew     <= '0;
        end else if (i_clear) begin
            r_valid    <= 1'b0;
            r_instr    <= NOP_INSTR;
            r_payload  <= '0;
            r_rd       <= '0;
            r_regwrite <= 1'b0;
            r_tnew     <= '0;
        end else if (i_load) begin
            r_valid    <= 1'b1;
            r_pc       <= i_pc;
            r_instr    <= i_instr;
            r_payload  <= i_payload;
            r_rd       <= i_rd;
            r_regwrite <= i_regwrite;
            r_tnew     <= i_tnew;
        end
    end

    assign o_valid    = r_valid;
    assign o_pc       = r_pc;
    assign o_instr    = r_instr;
    assign o_payload  = r_payload;
    assign o_rd       = r_rd;
    assign o_regwrite = r_regwrite;
    assign o_tnew     = r_tnew;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register placed between two core stages (F/D, D/E, E/M, M/W).
// Carries PC, instruction, payload and hazard fields; Tnew is decremented once on
// entry. Optional macro PIPE_SKID_EN adds a skid slot so in_ready is registered.
//
// Handshake: an entry moves on any cycle where valid and ready are both high;
// valid never waits on ready, and a presented entry stays stable until taken.
// flush empties every slot next cycle and silently drops an entry offered with it.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int          PAYLOAD_W = PAYLOAD_W_DEF,
    parameter int          RA_W      = RA_W_DEF,
    parameter int          TNEW_W    = TNEW_W_DEF,
    parameter logic [31:0] PC_RESET  = PC_RESET_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_pc,
    input  logic [31:0]          in_instr,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [RA_W-1:0]      in_rd,
    input  logic                 in_regwrite,
    input  logic [TNEW_W-1:0]    in_tnew,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_pc,
    output logic [31:0]          out_instr,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [RA_W-1:0]      out_rd,
    output logic                 out_regwrite,
    output logic [TNEW_W-1:0]    out_tnew,
    output logic                 out_fwd_en
);

    logic                 w_in_xfer;
    logic                 w_out_xfer;
    logic [TNEW_W-1:0]    w_tnew_load;
    logic                 w_main_load;
    logic                 w_main_clear;
    logic [31:0]          w_main_pc;
    logic [31:0]          w_main_instr;
    logic [PAYLOAD_W-1:0] w_main_payload;
    logic [RA_W-1:0]      w_main_rd;
    logic                 w_main_regwrite;
    logic [TNEW_W-1:0]    w_main_tnew;

    assign w_tnew_load = TNEW_W'(tnew_dec(TNEW_MAX_W'(in_tnew)));
    assign w_in_xfer   = in_valid & in_ready;
    assign w_out_xfer  = out_valid & out_ready;

`ifdef PIPE_SKID_EN
    logic                 w_main_free;
    logic                 w_skid_load;
    logic                 w_skid_clear;
    logic                 w_skid_valid;
    logic [31:0]          w_skid_pc;
    logic [31:0]          w_skid_instr;
    logic [PAYLOAD_W-1:0] w_skid_payload;
    logic [RA_W-1:0]      w_skid_rd;
    logic                 w_skid_regwrite;
    logic [TNEW_W-1:0]    w_skid_tnew;

    // Ready comes straight from the skid flag, so it never sees out_ready.
    assign in_ready     = ~w_skid_valid;
    assign w_main_free  = ~out_valid | out_ready;
    // Skid occupied implies main occupied, so the skid entry is always the older one.
    assign w_main_load  = ~flush & w_main_free & (w_skid_valid | w_in_xfer);
    assign w_main_clear = flush | (w_out_xfer & ~w_main_load);
    assign w_skid_load  = ~flush & w_in_xfer & out_valid & ~out_ready;
    assign w_skid_clear = flush | (w_skid_valid & w_main_free);

    assign w_main_pc       = w_skid_valid ? w_skid_pc       : in_pc;
    assign w_main_instr    = w_skid_valid ? w_skid_instr    : in_instr;
    assign w_main_payload  = w_skid_valid ? w_skid_payload  : in_payload;
    assign w_main_rd       = w_skid_valid ? w_skid_rd       : in_rd;
    assign w_main_regwrite = w_skid_valid ? w_skid_regwrite : in_regwrite;
    assign w_main_tnew     = w_skid_valid ? w_skid_tnew     : w_tnew_load;

    pipe_slot #(
        .PAYLOAD_W (PAYLOAD_W),
        .RA_W      (RA_W),
        .TNEW_W    (TNEW_W),
        .PC_RESET  (PC_RESET),
        .NOP_INSTR (NOP_INSTR)
    ) u_skid (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_skid_load),
        .i_clear    (w_skid_clear),
        .i_pc       (in_pc),
        .i_instr    (in_instr),
        .i_payload  (in_payload),
        .i_rd       (in_rd),
        .i_regwrite (in_regwrite),
        .i_tnew     (w_tnew_load),
        .o_valid    (w_skid_valid),
        .o_pc       (w_skid_pc),
        .o_instr    (w_skid_instr),
        .o_payload  (w_skid_payload),
        .o_rd       (w_skid_rd),
        .o_regwrite (w_skid_regwrite),
        .o_tnew     (w_skid_tnew)
    );
`else
    // Accept when empty or draining this cycle; during flush the offered entry is
    // consumed and dropped instead of stalling upstream.
    assign in_ready     = flush | ~out_valid | out_ready;
    assign w_main_load  = ~flush & w_in_xfer;
    assign w_main_clear = flush | (w_out_xfer & ~w_main_load);

    assign w_main_pc       = in_pc;
    assign w_main_instr    = in_instr;
    assign w_main_payload  = in_payload;
    assign w_main_rd       = in_rd;
    assign w_main_regwrite = in_regwrite;
    assign w_main_tnew     = w_tnew_load;
`endif

    pipe_slot #(
        .PAYLOAD_W (PAYLOAD_W),
        .RA_W      (RA_W),
        .TNEW_W    (TNEW_W),
        .PC_RESET  (PC_RESET),
        .NOP_INSTR (NOP_INSTR)
    ) u_main (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_main_load),
        .i_clear    (w_main_clear),
        .i_pc       (w_main_pc),
        .i_instr    (w_main_instr),
        .i_payload  (w_main_payload),
        .i_rd       (w_main_rd),
        .i_regwrite (w_main_regwrite),
        .i_tnew     (w_main_tnew),
        .o_valid    (out_valid),
        .o_pc       (out_pc),
        .o_instr    (out_instr),
        .o_payload  (out_payload),
        .o_rd       (out_rd),
        .o_regwrite (out_regwrite),
        .o_tnew     (out_tnew)
    );

    // Forwarding is only meaningful for a live entry that writes a non-zero register.
    assign out_fwd_en = out_valid & out_regwrite & (out_rd != '0);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg (works with or without PIPE_SKID_EN defined).
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int FW = $bits(stage_fields_t);

    logic                     clk;
    logic                     reset;
    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic [31:0]              in_pc;
    logic [31:0]              in_instr;
    logic [PAYLOAD_W_DEF-1:0] in_payload;
    logic [RA_W_DEF-1:0]      in_rd;
    logic                     in_regwrite;
    logic [TNEW_W_DEF-1:0]    in_tnew;
    logic                     out_valid;
    logic                     out_ready;
    logic [31:0]              out_pc;
    logic [31:0]              out_instr;
    logic [PAYLOAD_W_DEF-1:0] out_payload;
    logic [RA_W_DEF-1:0]      out_rd;
    logic                     out_regwrite;
    logic [TNEW_W_DEF-1:0]    out_tnew;
    logic                     out_fwd_en;

    pipe_stage_reg dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_instr     (in_instr),
        .in_payload   (in_payload),
        .in_rd        (in_rd),
        .in_regwrite  (in_regwrite),
        .in_tnew      (in_tnew),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_instr    (out_instr),
        .out_payload  (out_payload),
        .out_rd       (out_rd),
        .out_regwrite (out_regwrite),
        .out_tnew     (out_tnew),
        .out_fwd_en   (out_fwd_en)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [FW-1:0] exp_q[$];
    logic [31:0]   last_pc;
    int            n_checks;
    int            n_errors;
    int            n_out;
    int            cyc;
    int            stall_lo;
    int            stall_hi;
    logic          rdy_def;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic pick_ready();
        return (cyc >= stall_lo && cyc <= stall_hi) ? 1'b0 : rdy_def;
    endfunction

    // One clock: apply ready/flush, compare outputs at negedge, update the model.
    task automatic tick(input logic rdy, input logic fl, output logic accepted);
        stage_fields_t e;
        logic in_fire;
        logic out_fire;
        out_ready = rdy;
        flush     = fl;
        @(negedge clk);
        in_fire  = in_valid && in_ready;
        out_fire = out_valid && out_ready;
        chk("out_valid", 128'(out_valid), 128'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            e = stage_fields_t'(exp_q[0]);
            chk("pc",       128'(out_pc),       128'(e.pc));
            chk("instr",    128'(out_instr),    128'(e.instr));
            chk("payload",  128'(out_payload),  128'(e.payload));
            chk("rd",       128'(out_rd),       128'(e.rd));
            chk("regwrite", 128'(out_regwrite), 128'(e.regwrite));
            chk("tnew",     128'(out_tnew),     128'(e.tnew));
            chk("fwd_en",   128'(out_fwd_en),   128'(e.regwrite && (e.rd != 0)));
            last_pc = e.pc;
        end else begin
            chk("bubble_pc",       128'(out_pc),       128'(last_pc));
            chk("bubble_instr",    128'(out_instr),    128'(NOP_INSTR_DEF));
            chk("bubble_payload",  128'(out_payload),  128'(0));
            chk("bubble_rd",       128'(out_rd),       128'(0));
            chk("bubble_regwrite", 128'(out_regwrite), 128'(0));
            chk("bubble_tnew",     128'(out_tnew),     128'(0));
            chk("bubble_fwd_en",   128'(out_fwd_en),   128'(0));
        end
        if (out_fire) begin
            n_out++;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        if (fl) begin
            exp_q.delete();
        end else if (in_fire) begin
            e.pc       = in_pc;
            e.instr    = in_instr;
            e.payload  = in_payload;
            e.rd       = in_rd;
            e.regwrite = in_regwrite;
            e.tnew     = (in_tnew == 0) ? 4'd0 : in_tnew - 4'd1;
            exp_q.push_back(FW'(e));
        end
        accepted = in_fire;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    // Offer one entry until accepted (bounded), then drop in_valid.
    task automatic send(input logic [31:0] pc, input logic [31:0] instr,
                        input logic [PAYLOAD_W_DEF-1:0] pl, input logic [RA_W_DEF-1:0] rd,
                        input logic rw, input logic [TNEW_W_DEF-1:0] tn);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1; in_pc = pc; in_instr = instr; in_payload = pl;
        in_rd = rd; in_regwrite = rw; in_tnew = tn;
        for (int k = 0; k < 40 && !acc; k++) tick(pick_ready(), 1'b0, acc);
        chk("send_accept", 128'(acc), 128'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        logic acc;
        in_valid = 1'b0;
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick(1'b1, 1'b0, acc);
        tick(1'b1, 1'b0, acc);
    endtask

    task automatic do_reset(input int n);
        in_valid = 1'b0;
        reset    = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        last_pc = PC_RESET_DEF;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic acc;
        int   base;
        n_checks = 0; n_errors = 0; n_out = 0; cyc = 0;
        stall_lo = -1; stall_hi = -1; rdy_def = 1'b1;
        flush = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
        in_pc = '0; in_instr = '0; in_payload = '0; in_rd = '0; in_regwrite = 1'b0; in_tnew = '0;
        last_pc = PC_RESET_DEF;

        // Reset for two cycles, then observe the idle bubble.
        do_reset(2);
        tick(1'b1, 1'b0, acc);
        chk("rst_in_ready", 128'(in_ready), 128'(1));

        // Single entries: tnew 2 -> 1 with forwarding, tnew 0 stays 0.
        send(32'h3004, 32'h3c01_1234, 96'h1, 5'd1, 1'b1, 4'd2);
        send(32'h3008, 32'h0000_0020, 96'h2, 5'd3, 1'b1, 4'd0);
        send(32'h300c, 32'h1234_5678, 96'h3, 5'd7, 1'b0, 4'd15);
        drain();

        // Stream of eight with a three-cycle downstream stall.
        base = n_out;
        stall_lo = cyc + 3; stall_hi = cyc + 5;
        for (int i = 0; i < 8; i++)
            send(32'h3100 + 32'(i * 4), $urandom, {$urandom, $urandom, $urandom},
                 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        drain();
        stall_lo = -1; stall_hi = -1;
        chk("stream_count", 128'(n_out - base), 128'(8));

        // Flush while full with a new entry offered: bubble next, entry dropped.
        rdy_def = 1'b0;
        send(32'h3200, 32'haaaa_0001, 96'h55, 5'd9, 1'b1, 4'd3);
        in_valid = 1'b1; in_pc = 32'h3204; in_instr = 32'hbbbb_0002; in_rd = 5'd10;
        in_regwrite = 1'b1; in_tnew = 4'd1; in_payload = 96'h66;
        tick(1'b0, 1'b1, acc);
        chk("flush_drop_accept", 128'(acc), 128'(1));
        in_valid = 1'b0;
        tick(1'b0, 1'b0, acc);
        chk("flush_pc_kept", 128'(out_pc), 128'(32'h3200));
        rdy_def = 1'b1;
        drain();

        // Reset while stalled full (skid slot filled when present).
        rdy_def = 1'b0;
        send(32'h3300, 32'hcccc_0003, 96'h77, 5'd4, 1'b1, 4'd2);
        in_valid = 1'b1; in_pc = 32'h3304; in_instr = 32'hdddd_0004; in_rd = 5'd5;
        in_regwrite = 1'b1; in_tnew = 4'd2; in_payload = 96'h88;
        tick(1'b0, 1'b0, acc);
        in_valid = 1'b0;
        tick(1'b0, 1'b0, acc);
        do_reset(1);
        tick(1'b1, 1'b0, acc);
        chk("rst2_pc", 128'(out_pc), 128'(32'h3000));
        rdy_def = 1'b1;

        // rd = 0 with regwrite: no forwarding.
        send(32'h3400, 32'h0000_0001, 96'h9, 5'd0, 1'b1, 4'd1);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
